tlp_hdr_tx: RTL
===============

// Module: tlp_hdr_tx
// PURPOSE
// - Transmit side of the TLP detector path: turns a one-hot TLP-type request plus fields into a serialized 3DW TLP.
// - Output is a byte stream (fmt/type byte first) with sop/eop/valid/ready framing.
// - The fmt/type byte is the exact encoding the detector's type decoder recognises, so TX->detector loopback is lossless.
// PARAMETERS
// - REQ_ID   16'h0100  requester ID in request headers; completer ID in completion headers
// - CNT_W    16        width of the sent-TLP counter
// PORTS
// - clk         in   1      single clock, rising edge
// - rst_n       in   1      asynchronous, active-low reset
// - req_valid   in   1      request present
// - req_ready   out  1      block idle; request accepted on req_valid&&req_ready
// - req_type    in   10     one-hot type: [0]MRd32=00 [1]MRdLk=01 [2]IORd=02 [3]IOWr=42 [4]CfgRd0=04 [5]CfgWr0=44 [6]CfgRd1=05 [7]CfgWr1=45 [8]Cpl=0A [9]CplD=4A
// - req_length  in   10     DW length field; sent as-is for MRd32/MRdLk, forced to 1 for all other types
// - req_addr    in   32     address / cfg target; for Cpl/CplD: [31:16] requester ID, [6:0] lower address
// - req_tag     in   8      tag
// - req_data    in   32     single-DW payload for types with fmt bit6 set (IOWr, CfgWr0/1, CplD)
// - tx_data     out  8      stream byte
// - tx_valid    out  1      byte valid
// - tx_ready    in   1      sink accepts byte on tx_valid&&tx_ready
// - tx_sop      out  1      first byte of TLP
// - tx_eop      out  1      last byte of TLP
// - err_type    out  1      1-cycle pulse: accepted req_type was not exactly one-hot
// - tlp_count   out  CNT_W  TLPs completed (eop handshaken); wraps at 2^CNT_W
// BEHAVIOUR
// - Reset: req_ready=0 while rst_n low, then 1; tx_valid/tx_sop/tx_eop/err_type=0; tx_data=8'h00; tlp_count=0; FSM=IDLE.
// - FSM: IDLE -> HDR on accept of a valid one-hot request; HDR -> PAY after byte 11 handshaken if the type carries data, else -> IDLE; PAY -> IDLE after byte 15.
// - Request capture: all req_* fields registered on accept; later input changes have no effect on the TLP in flight.
// - req_ready=1 only in IDLE; one-cycle gap between eop handshake and the next accept.
// - Latency: byte 0 on tx_valid in the cycle after accept; with tx_ready held 1, one byte per cycle.
// - Backpressure: tx_valid=0 && tx_ready=1 advances nothing; while tx_ready=0, tx_data/sop/eop held stable.
// - Header bytes 0..11:
//   - b0 fmt/type; b1 8'h00; b2 {6'b0,len[9:8]}; b3 len[7:0].
//   - Requests: b4-5 REQ_ID; b6 tag; b7 8'h0F (lastBE=0, firstBE=F); b8-11 {addr[31:2],2'b00}.
//   - Cpl/CplD: b4-5 REQ_ID; b6 {3'b000 status,1'b0,4'h0}; b7 byte count = 8'h04 (CplD) / 8'h00 (Cpl); b8-9 addr[31:16]; b10 tag; b11 {1'b0,addr[6:0]}.
// - Payload: bytes 12..15 = req_data[31:24], [23:16], [15:8], [7:0].
// - tx_sop=1 on byte 0 only; tx_eop=1 on byte 11 (no data) or byte 15 (data); the same byte never carries both.
// - Non-one-hot req_type (including 0) is accepted: err_type pulses 1 cycle after accept, no tx_valid, FSM stays IDLE.
// - tlp_count increments on the eop handshake; 2^CNT_W-1 wraps to 0.
// - Reset mid-packet: outputs clear immediately; the partial TLP is abandoned with no eop and no count.
// STRUCTURE
// - Package tlp_pkg:
//   - fmt/type byte localparams (FT_MRD32=8'h00 ... FT_CPLD=8'h4A);
//   - one-hot index constants; HDR_BYTES=12; PAY_BYTES=4.
// - Sub-module tlp_fmt_type_enc (combinational):
//   - req_type[9:0] -> fmt_type[7:0], onehot_ok, has_data (fmt_type[6]).
//   - Inverse of the detector's type decoder.
// - Top: FSM, 4-bit byte counter, field registers, byte mux, tlp_count.
// TESTING
// - MRd32 len=1 addr=32'h1000_0004 tag=8'h0F, tx_ready=1:
//   - 12 bytes 00 00 00 01 01 00 0F 0F 10 00 00 04;
//   - sop on byte 0, eop on byte 11; tlp_count=1.
// - IOWr data=32'hDEADBEEF, req_length=5:
//   - b0=42, b3=01 (forced length);
//   - bytes 12-15 DE AD BE EF; eop on byte 15 only.
// - CplD addr=32'h0100_0045 tag=8'h22:
//   - b0=4A, b7=04, b8-9=01 00, b10=22, b11=45.
// - tx_ready toggled 1/0 during CfgWr0:
//   - tx_data is stable across every stall; the byte sequence matches the unstalled run;
//   - req_ready stays 0 until after eop.
// - req_type=10'h003: err_type pulses 1 cycle, tx_valid stays 0, tlp_count unchanged.
// - rst_n low at byte 6 of an MRdLk:
//   - tx_valid drops asynchronously; no eop; tlp_count=0;
//   - the next MRd32 starts with sop on byte 0.
// - Loopback: byte 0 of each of the 10 types fed to the detector's type decoder returns the same one-hot value as req_type.

Source files
------------

// File: rtl/tlp_pkg.sv
// ---------------------------------------------------------------------------
// tlp_pkg
// Shared constants for the TLP transmit path.
//   - FT_*       fmt/type byte values, identical to what the detector's type
//                decoder matches on, so TX -> detector loopback is lossless
//   - IDX_*      bit positions of each type in the one-hot req_type vector
//   - HDR_BYTES / PAY_BYTES and the derived last-byte indices
//   - tx_state_e transmit FSM states
// ---------------------------------------------------------------------------
package tlp_pkg;

    localparam logic [7:0] FT_MRD32  = 8'h00;
    localparam logic [7:0] FT_MRDLK  = 8'h01;
    localparam logic [7:0] FT_IORD   = 8'h02;
    localparam logic [7:0] FT_IOWR   = 8'h42;
    localparam logic [7:0] FT_CFGRD0 = 8'h04;
    localparam logic [7:0] FT_CFGWR0 = 8'h44;
    localparam logic [7:0] FT_CFGRD1 = 8'h05;
    localparam logic [7:0] FT_CFGWR1 = 8'h45;
    localparam logic [7:0] FT_CPL    = 8'h0A;
    localparam logic [7:0] FT_CPLD   = 8'h4A;

    localparam int IDX_MRD32  = 0;
    localparam int IDX_MRDLK  = 1;
    localparam int IDX_IORD   = 2;
    localparam int IDX_IOWR   = 3;
    localparam int IDX_CFGRD0 = 4;
    localparam int IDX_CFGWR0 = 5;
    localparam int IDX_CFGRD1 = 6;
    localparam int IDX_CFGWR1 = 7;
    localparam int IDX_CPL    = 8;
    localparam int IDX_CPLD   = 9;
    localparam int NUM_TYPES  = 10;

    localparam int HDR_BYTES = 12;
    localparam int PAY_BYTES = 4;

    localparam logic [3:0] LAST_HDR_BYTE = 4'(HDR_BYTES - 1);
    localparam logic [3:0] LAST_PAY_BYTE = 4'(HDR_BYTES + PAY_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2
    } tx_state_e;

endpackage

// File: rtl/tlp_fmt_type_enc.sv
// ---------------------------------------------------------------------------
// tlp_fmt_type_enc
// Combinational one-hot request type -> fmt/type byte encoder; the exact
// inverse of the detector's type decoder.
//   req_type  in  10  one-hot type request
//   fmt_type  out 8   fmt/type byte (00 when req_type is not one-hot)
//   onehot_ok out 1   req_type has exactly one bit set
//   has_data  out 1   type carries a one-DW payload (fmt bit 6)
// ---------------------------------------------------------------------------
module tlp_fmt_type_enc
    import tlp_pkg::*;
(
    input  logic [NUM_TYPES-1:0] req_type,
    output logic [7:0]           fmt_type,
    output logic                 onehot_ok,
    output logic                 has_data
);

    always_comb begin
        fmt_type  = 8'h00;
        onehot_ok = 1'b1;
        case (req_type)
            10'h001: fmt_type = FT_MRD32;
            10'h002: fmt_type = FT_MRDLK;
            10'h004: fmt_type = FT_IORD;
            10'h008: fmt_type = FT_IOWR;
            10'h010: fmt_type = FT_CFGRD0;
            10'h020: fmt_type = FT_CFGWR0;
            10'h040: fmt_type = FT_CFGRD1;
            10'h080: fmt_type = FT_CFGWR1;
            10'h100: fmt_type = FT_CPL;
            10'h200: fmt_type = FT_CPLD;
            default: onehot_ok = 1'b0;
        endcase
        has_data = fmt_type[6];
    end

endmodule

// File: rtl/tlp_hdr_tx.sv
// ---------------------------------------------------------------------------
// tlp_hdr_tx
// Serialises a one-hot TLP request into a 3DW header (plus one payload DW
// for write/CplD types) as a byte stream with sop/eop/valid/ready framing.
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_type/length/addr/tag/data  request fields, captured on accept
//   tx_data/valid/ready/sop/eop    output byte stream
//   err_type              1-cycle pulse after accepting a non-one-hot type
//   tlp_count             number of TLPs whose eop byte was handshaken
// ---------------------------------------------------------------------------
module tlp_hdr_tx
    import tlp_pkg::*;
#(
    parameter logic [15:0] REQ_ID = 16'h0100,
    parameter int          CNT_W  = 16
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [NUM_TYPES-1:0] req_type,
    input  logic [9:0]           req_length,
    input  logic [31:0]          req_addr,
    input  logic [7:0]           req_tag,
    input  logic [31:0]          req_data,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 tx_sop,
    output logic                 tx_eop,
    output logic                 err_type,
    output logic [CNT_W-1:0]     tlp_count
);

    tx_state_e        state_q, state_d;
    logic [3:0]       byteCnt_q, byteCnt_d;
    logic [7:0]       fmtType_q;
    logic             hasData_q;
    logic             isCpl_q;
    logic [9:0]       length_q;
    logic [31:0]      addr_q;
    logic [7:0]       tag_q;
    logic [31:0]      data_q;
    logic             err_q;
    logic [CNT_W-1:0] count_q, count_d;

    logic [7:0] encFmtType;
    logic       encOnehotOk;
    logic       encHasData;
    logic       accept;
    logic       txFire;

    tlp_fmt_type_enc u_enc (
        .req_type  (req_type),
        .fmt_type  (encFmtType),
        .onehot_ok (encOnehotOk),
        .has_data  (encHasData)
    );

    // rst_n gates ready so nothing is accepted while reset is held.
    assign req_ready = (state_q == ST_IDLE) && rst_n;
    assign accept    = req_valid && req_ready;
    assign tx_valid  = (state_q != ST_IDLE);
    assign txFire    = tx_valid && tx_ready;
    assign tx_sop    = tx_valid && (byteCnt_q == 4'd0);
    assign tx_eop    = tx_valid && (hasData_q ? (byteCnt_q == LAST_PAY_BYTE)
                                              : (byteCnt_q == LAST_HDR_BYTE));
    assign err_type  = err_q;
    assign tlp_count = count_q;

    always_comb begin
        state_d   = state_q;
        byteCnt_d = byteCnt_q;
        count_d   = count_q;
        case (state_q)
            ST_IDLE: begin
                byteCnt_d = 4'd0;
                if (accept && encOnehotOk) begin
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (txFire) begin
                    if (byteCnt_q == LAST_HDR_BYTE) begin
                        if (hasData_q) begin
                            state_d   = ST_PAY;
                            byteCnt_d = byteCnt_q + 4'd1;
                        end else begin
                            state_d   = ST_IDLE;
                            byteCnt_d = 4'd0;
                        end
                    end else begin
                        byteCnt_d = byteCnt_q + 4'd1;
                    end
                end
            end
            ST_PAY: begin
                if (txFire) begin
                    if (byteCnt_q == LAST_PAY_BYTE) begin
                        state_d   = ST_IDLE;
                        byteCnt_d = 4'd0;
                    end else begin
                        byteCnt_d = byteCnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                byteCnt_d = 4'd0;
            end
        endcase
        if (txFire && tx_eop) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            byteCnt_q <= 4'd0;
            err_q     <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            byteCnt_q <= byteCnt_d;
            err_q     <= accept && !encOnehotOk;
            count_q   <= count_d;
        end
    end

    // Length is forced to 1 DW for everything except the memory reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fmtType_q <= 8'h00;
            hasData_q <= 1'b0;
            isCpl_q   <= 1'b0;
            length_q  <= 10'd0;
            addr_q    <= 32'd0;
            tag_q     <= 8'd0;
            data_q    <= 32'd0;
        end else if (accept && encOnehotOk) begin
            fmtType_q <= encFmtType;
            hasData_q <= encHasData;
            isCpl_q   <= req_type[IDX_CPL] || req_type[IDX_CPLD];
            length_q  <= (req_type[IDX_MRD32] || req_type[IDX_MRDLK]) ? req_length : 10'd1;
            addr_q    <= req_addr;
            tag_q     <= req_tag;
            data_q    <= req_data;
        end
    end

    // Bytes 6..11 differ between request and completion header layouts.
    always_comb begin
        tx_data = 8'h00;
        if (tx_valid) begin
            case (byteCnt_q)
                4'd0:  tx_data = fmtType_q;
                4'd1:  tx_data = 8'h00;
                4'd2:  tx_data = {6'b0, length_q[9:8]};
                4'd3:  tx_data = length_q[7:0];
                4'd4:  tx_data = REQ_ID[15:8];
                4'd5:  tx_data = REQ_ID[7:0];
                4'd6:  tx_data = isCpl_q ? 8'h00 : tag_q;
                4'd7:  tx_data = isCpl_q ? (hasData_q ? 8'h04 : 8'h00) : 8'h0F;
                4'd8:  tx_data = addr_q[31:24];
                4'd9:  tx_data = addr_q[23:16];
                4'd10: tx_data = isCpl_q ? tag_q : addr_q[15:8];
                4'd11: tx_data = isCpl_q ? {1'b0, addr_q[6:0]} : {addr_q[7:2], 2'b00};
                4'd12: tx_data = data_q[31:24];
                4'd13: tx_data = data_q[23:16];
                4'd14: tx_data = data_q[15:8];
                4'd15: tx_data = data_q[7:0];
                default: tx_data = 8'h00;
            endcase
        end
    end

endmodule
